// File: rtl/pulse_cond_pkg.sv
// Shared types and constants for the input-conditioning blocks.
// Holds the debouncer FSM state encoding, the glitch counter geometry,
// the default tuning values and a saturating increment helper.
package pulse_cond_pkg;

    // Debouncer FSM states: two settled levels and two qualification states.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } deb_state_t;

    // Glitch counter geometry.
    localparam int                  GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

    // Default tuning values.
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_SYNC_STAGES     = 2;

    // Increment that sticks at GLITCH_MAX instead of wrapping to zero.
    function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] value);
        logic [GLITCH_W-1:0] result;
        if (value == GLITCH_MAX) begin
            result = value;
        end else begin
            result = value + GLITCH_W'(1);
        end
        return result;
    endfunction

endpackage : pulse_cond_pkg

// File: rtl/sync_chain.sv
// N-flop synchroniser bringing an asynchronous level into the clk domain.
// All flops clear to 0 on the asynchronous reset, so the chain never
// presents a stale 1 to downstream logic after reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_reg;

    // Shift the raw level through the flop chain; bit 0 is the metastable catcher.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_reg <= '0;
        end else begin
            ff_reg <= {ff_reg[STAGES-2:0], d};
        end
    end

    assign q = ff_reg[STAGES-1];

endmodule : sync_chain

// File: rtl/pulse_debouncer.sv
// Debouncer for asynchronous, bouncy inputs (buttons, external strobes).
// The raw input is synchronised, then a counter-based FSM only accepts a
// new level after DEBOUNCE_CYCLES consecutive identical samples. Accepted
// edges produce one-cycle pulses; rejected bounces bump a saturating
// diagnostic counter.
//
// Optional feature macro: PULSE_DEB_FALL_EN
//   defined   -> fall_pulse port present, pulses on each accepted fall
//   undefined -> no fall_pulse port or register; falls still move level_out
module pulse_debouncer
    import pulse_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_in,
    input  logic                enable,
    input  logic                glitch_clr,
    output logic                level_out,
    output logic                rise_pulse,
`ifdef PULSE_DEB_FALL_EN
    output logic                fall_pulse,
`endif
    output logic [GLITCH_W-1:0] glitch_count
);

    // Counter value at which the final qualifying sample is taken.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Catch illegal parameterisations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("pulse_debouncer: SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
        $error("pulse_debouncer: DEBOUNCE_CYCLES must be in 2..65535");
    end

    logic       s;
    deb_state_t state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic       glitch_event;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (s)
    );

    // A glitch is a qualification aborted by the input reverting while enabled.
    // Disable-driven aborts are deliberately not counted.
    always_comb begin
        glitch_event = 1'b0;
        if (enable) begin
            if (state_reg == WAIT_HIGH && !s) begin
                glitch_event = 1'b1;
            end else if (state_reg == WAIT_LOW && s) begin
                glitch_event = 1'b1;
            end
        end
    end

    // Debounce FSM with registered level and edge-pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= STABLE_LOW;
            cnt_reg    <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
`ifdef PULSE_DEB_FALL_EN
            fall_pulse <= 1'b0;
`endif
        end else begin
            // Pulses last a single cycle unless re-armed below.
            rise_pulse <= 1'b0;
`ifdef PULSE_DEB_FALL_EN
            fall_pulse <= 1'b0;
`endif
            if (!enable) begin
                // Abandon any pending qualification; the settled level is held.
                case (state_reg)
                    WAIT_HIGH: state_reg <= STABLE_LOW;
                    WAIT_LOW:  state_reg <= STABLE_HIGH;
                    default:   state_reg <= state_reg;
                endcase
                cnt_reg <= '0;
            end else begin
                case (state_reg)
                    STABLE_LOW: begin
                        if (s) begin
                            state_reg <= WAIT_HIGH;
                            cnt_reg   <= CNT_ONE;
                        end
                    end
                    WAIT_HIGH: begin
                        if (s) begin
                            if (cnt_reg == CNT_LAST) begin
                                state_reg  <= STABLE_HIGH;
                                level_out  <= 1'b1;
                                rise_pulse <= 1'b1;
                                cnt_reg    <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end else begin
                            state_reg <= STABLE_LOW;
                            cnt_reg   <= '0;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!s) begin
                            state_reg <= WAIT_LOW;
                            cnt_reg   <= CNT_ONE;
                        end
                    end
                    WAIT_LOW: begin
                        if (!s) begin
                            if (cnt_reg == CNT_LAST) begin
                                state_reg  <= STABLE_LOW;
                                level_out  <= 1'b0;
`ifdef PULSE_DEB_FALL_EN
                                fall_pulse <= 1'b1;
`endif
                                cnt_reg    <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end else begin
                            state_reg <= STABLE_HIGH;
                            cnt_reg   <= '0;
                        end
                    end
                    default: begin
                        state_reg <= STABLE_LOW;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    // Saturating glitch counter; a clear beats a coincident glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_count <= '0;
        end else if (glitch_clr) begin
            glitch_count <= '0;
        end else if (glitch_event) begin
            glitch_count <= glitch_sat_inc(glitch_count);
        end
    end

endmodule : pulse_debouncer

// File: tb/tb_pulse_debouncer.sv
// Directed bench for pulse_debouncer with a pulse scoreboard.
// Expected pulse cycles are queued when a clean step is driven and popped
// when the DUT emits the pulse; static values are checked inline.
module tb_pulse_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
    // Edges from driving a step (just after edge N) to the pulse edge:
    // first sync sample at N+1, then SYNC+DEB-1 further edges.
    localparam int STEP_LAT = 1 + SYNC + DEB - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_in;
    logic       enable;
    logic       glitch_clr;
    logic       level_out;
    logic       rise_pulse;
`ifdef PULSE_DEB_FALL_EN
    logic       fall_pulse;
`endif
    logic [7:0] glitch_count;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int rise_q[$];
    int fall_q[$];
    int rise_exp;
    int fall_exp;
    int exp_glitch;

    pulse_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_in       (raw_in),
        .enable       (enable),
        .glitch_clr   (glitch_clr),
        .level_out    (level_out),
        .rise_pulse   (rise_pulse),
`ifdef PULSE_DEB_FALL_EN
        .fall_pulse   (fall_pulse),
`endif
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rise_pulse === 1'b1) begin
            $display("cycle %0d: rise_pulse seen, level_out=%0b", cyc, level_out);
            check("rise_was_expected", rise_q.size() > 0, 1);
            if (rise_q.size() > 0) begin
                rise_exp = rise_q.pop_front();
                check("rise_cycle", cyc, rise_exp);
            end
            check("level_at_rise", level_out, 1);
        end
`ifdef PULSE_DEB_FALL_EN
        if (fall_pulse === 1'b1) begin
            $display("cycle %0d: fall_pulse seen, level_out=%0b", cyc, level_out);
            check("fall_was_expected", fall_q.size() > 0, 1);
            if (fall_q.size() > 0) begin
                fall_exp = fall_q.pop_front();
                check("fall_cycle", cyc, fall_exp);
            end
            check("level_at_fall", level_out, 0);
            check("rise_fall_exclusive", rise_pulse, 0);
        end
`endif
    end

    // Clean fall from a settled high level; level must drop exactly on time.
    task automatic clean_fall(input string tag);
        raw_in = 1'b0;
`ifdef PULSE_DEB_FALL_EN
        fall_q.push_back(cyc + STEP_LAT);
`endif
        tick(STEP_LAT - 1);
        check({tag, "_level_before"}, level_out, 1);
        tick(1);
        check({tag, "_level_after"}, level_out, 0);
        $display("cycle %0d: %s done, level_out=%0b", cyc, tag, level_out);
        tick(3);
    endtask

    initial begin
        rst        = 1'b1;
        raw_in     = 1'b0;
        enable     = 1'b1;
        glitch_clr = 1'b0;
        exp_glitch = 0;

        // Reset state.
        tick(3);
        check("rst_level", level_out, 0);
        check("rst_rise", rise_pulse, 0);
        check("rst_glitch", glitch_count, 0);
`ifdef PULSE_DEB_FALL_EN
        check("rst_fall", fall_pulse, 0);
`endif
        rst = 1'b0;
        tick(50);
        check("idle_level", level_out, 0);
        check("idle_glitch", glitch_count, 0);
        $display("cycle %0d: idle after reset checked", cyc);

        // Clean rise: pulse 17 cycles after the sampling edge.
        raw_in = 1'b1;
        rise_q.push_back(cyc + STEP_LAT);
        tick(STEP_LAT - 1);
        check("rise_level_before", level_out, 0);
        tick(1);
        check("rise_level_after", level_out, 1);
        tick(5);
        check("rise_level_hold", level_out, 1);
        check("rise_glitch", glitch_count, 0);
        clean_fall("fall1");

        // Three short high bursts (3-cycle segments) are each rejected,
        // then a steady high is accepted once.
        for (int i = 0; i < 3; i++) begin
            raw_in = 1'b1;
            tick(3);
            raw_in = 1'b0;
            tick(3);
            exp_glitch++;
        end
        raw_in = 1'b1;
        rise_q.push_back(cyc + STEP_LAT);
        tick(12);
        check("bounce_glitch", glitch_count, exp_glitch);
        check("bounce_level_early", level_out, 0);
        tick(10);
        check("bounce_level_final", level_out, 1);
        $display("cycle %0d: bounce done, glitch_count=%0d", cyc, glitch_count);
        clean_fall("fall2");

        // Many 2-sample glitches: counts up, then saturates at 255.
        for (int i = 0; i < 200; i++) begin
            raw_in = 1'b1;
            tick(2);
            raw_in = 1'b0;
            tick(2);
            exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
        end
        tick(4);
        check("glitch_203", glitch_count, exp_glitch);
        for (int i = 0; i < 100; i++) begin
            raw_in = 1'b1;
            tick(2);
            raw_in = 1'b0;
            tick(2);
            exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
        end
        tick(4);
        check("glitch_saturated", glitch_count, exp_glitch);
        $display("cycle %0d: glitch_count=%0d after 300 glitches", cyc, glitch_count);

        // Clear coincident with a glitch event: clear wins.
        raw_in = 1'b1;
        tick(2);
        raw_in = 1'b0;
        tick(2);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("clr_vs_glitch", glitch_count, 0);
        tick(3);
        check("clr_hold", glitch_count, 0);

        // A fresh glitch after the clear counts from zero.
        raw_in = 1'b1;
        tick(2);
        raw_in = 1'b0;
        tick(6);
        check("glitch_after_clr", glitch_count, 1);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("clr_alone", glitch_count, 0);

        // Enable dropped at cnt=10 in WAIT_HIGH, raw stays high.
        raw_in = 1'b1;
        tick(12);
        enable = 1'b0;
        tick(20);
        check("dis_glitch", glitch_count, 0);
        check("dis_level", level_out, 0);
        enable = 1'b1;
        rise_q.push_back(cyc + DEB);
        tick(DEB - 1);
        check("reen_level_before", level_out, 0);
        tick(1);
        check("reen_level_after", level_out, 1);
        check("reen_glitch", glitch_count, 0);
        $display("cycle %0d: re-enable rise done", cyc);
        tick(3);
        clean_fall("fall3");

        // Reset in the middle of WAIT_LOW abandons the fall.
        raw_in = 1'b1;
        rise_q.push_back(cyc + STEP_LAT);
        tick(25);
        check("pre_rst_level", level_out, 1);
        raw_in = 1'b0;
        tick(8);
        rst = 1'b1;
        #1;
        check("midrst_level", level_out, 0);
        check("midrst_rise", rise_pulse, 0);
        check("midrst_glitch", glitch_count, 0);
`ifdef PULSE_DEB_FALL_EN
        check("midrst_fall", fall_pulse, 0);
`endif
        tick(2);
        rst = 1'b0;
        tick(30);
        check("post_rst_level", level_out, 0);
        check("post_rst_glitch", glitch_count, 0);
        $display("cycle %0d: reset mid-WAIT_LOW done", cyc);

        // Raw held high through reset release: a normal accepted rise.
        rst    = 1'b1;
        raw_in = 1'b1;
        tick(3);
        rst = 1'b0;
        rise_q.push_back(cyc + STEP_LAT);
        tick(STEP_LAT - 1);
        check("rst_high_level_before", level_out, 0);
        tick(1);
        check("rst_high_level_after", level_out, 1);
        tick(3);

        // Every queued pulse must have appeared.
        check("rise_q_drained", rise_q.size(), 0);
        check("fall_q_drained", fall_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_pulse_debouncer
